// File: rtl/window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : window_gen                                                      |
// | Brief    : 3x3 neighbourhood builder with output throttle for edge detect  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MIN_GAP    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startFrame,
    input  logic [3:0]           pixIn,
    input  logic                 pixValid,
    output logic                 pixReady,
    output logic [2:0][2:0][3:0] pixelData,
    output logic                 windowValid,
    output logic [9:0]           winXVal,
    output logic [8:0]           winYVal,
    output logic                 frameDone
);

    localparam int              c_AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int              c_GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [9:0]      c_X_LAST   = 10'(IMG_WIDTH - 1);
    localparam logic [8:0]      c_Y_LAST   = 9'(IMG_HEIGHT - 1);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(MIN_GAP - 1);

    // r_lb1 holds row y-1, r_lb2 holds row y-2 for the column being accepted
    logic [3:0]           r_lb1 [IMG_WIDTH];
    logic [3:0]           r_lb2 [IMG_WIDTH];

    logic [9:0]           r_x;
    logic [8:0]           r_y;
    logic [c_GW-1:0]      r_gap;
    logic [2:0][1:0][3:0] r_win;
    logic [2:0][2:0][3:0] r_pixelData;
    logic                 r_windowValid;
    logic [9:0]           r_winX;
    logic [8:0]           r_winY;
    logic                 r_frameDone;

    logic                 w_acc;
    logic [9:0]           w_ex;
    logic [8:0]           w_ey;
    logic [c_AW-1:0]      w_addr;
    logic [2:0][3:0]      w_col;
    logic [2:0][2:0][3:0] w_shift;
    logic                 w_xlast;
    logic                 w_ylast;
    logic                 w_emit;

    assign pixReady = ~reset & (r_gap == '0);
    assign w_acc    = pixValid & pixReady;

    // startFrame re-targets the current accept to (0,0)
    assign w_ex     = startFrame ? 10'd0 : r_x;
    assign w_ey     = startFrame ? 9'd0  : r_y;
    assign w_addr   = w_ex[c_AW-1:0];
    assign w_xlast  = (w_ex == c_X_LAST);
    assign w_ylast  = (w_ey == c_Y_LAST);
    assign w_emit   = w_acc & ~startFrame & (w_ex >= 10'd2) & (w_ey >= 9'd2);

    assign w_col[0] = r_lb2[w_addr];
    assign w_col[1] = r_lb1[w_addr];
    assign w_col[2] = pixIn;

    always_comb begin
        w_shift = '0;
        for (int r = 0; r < 3; r++) begin
            w_shift[r][0] = r_win[r][0];
            w_shift[r][1] = r_win[r][1];
            w_shift[r][2] = w_col[r];
        end
    end

    // Line buffers: reads above are taken before these writes land
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb2[w_addr] <= r_lb1[w_addr];
            r_lb1[w_addr] <= pixIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_gap         <= '0;
            r_win         <= '0;
            r_pixelData   <= '0;
            r_windowValid <= 1'b0;
            r_winX        <= '0;
            r_winY        <= '0;
            r_frameDone   <= 1'b0;
        end else begin
            r_windowValid <= w_emit;
            r_frameDone   <= w_acc & w_xlast & w_ylast;

            if (w_acc) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= w_col[r];
                end
                if (w_xlast) begin
                    r_x <= '0;
                    r_y <= w_ylast ? 9'd0 : w_ey + 9'd1;
                end else begin
                    r_x <= w_ex + 10'd1;
                    r_y <= w_ey;
                end
            end else if (startFrame) begin
                r_x <= '0;
                r_y <= '0;
            end

            if (w_emit) begin
                r_pixelData <= w_shift;
                r_winX      <= w_ex - 10'd1;
                r_winY      <= w_ey - 9'd1;
            end

            if (startFrame) begin
                r_gap <= '0;
            end else if (w_emit) begin
                r_gap <= c_GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign pixelData   = r_pixelData;
    assign windowValid = r_windowValid;
    assign winXVal     = r_winX;
    assign winYVal     = r_winY;
    assign frameDone   = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_window_gen                                                   |
// | Brief    : Bench for window_gen, MIN_GAP=6 and MIN_GAP=1 instances         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        bit         rst;
        bit         sf;
        bit         vld;
        logic [3:0] pix;
        bit         rdy;
        bit         wv;
        bit         chkpd;
        logic [35:0] pd;
    } vec_t;

    logic clk;
    logic reset, startFrame, pixValid;
    logic [3:0] pixIn;

    logic                 o_rdy [2];
    logic [2:0][2:0][3:0] o_pd  [2];
    logic                 o_wv  [2];
    logic [9:0]           o_x   [2];
    logic [8:0]           o_y   [2];
    logic                 o_fd  [2];

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    int                   m_idx     [2];
    longint               last_emit [2];
    logic [3:0]           img       [2][H][W];
    bit                   e_wv      [2];
    bit                   e_fd      [2];
    logic [2:0][2:0][3:0] e_pd      [2];
    int                   e_x       [2];
    int                   e_y       [2];

    int     wv_cnt [2];
    longint last_wv[2];
    longint min_sp [2];
    bit     obs_ready0;

    window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_GAP(6)) dut0 (
        .clk(clk), .reset(reset), .startFrame(startFrame), .pixIn(pixIn),
        .pixValid(pixValid), .pixReady(o_rdy[0]), .pixelData(o_pd[0]),
        .windowValid(o_wv[0]), .winXVal(o_x[0]), .winYVal(o_y[0]),
        .frameDone(o_fd[0])
    );

    window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .startFrame(startFrame), .pixIn(pixIn),
        .pixValid(pixValid), .pixReady(o_rdy[1]), .pixelData(o_pd[1]),
        .windowValid(o_wv[1]), .winXVal(o_x[1]), .winYVal(o_y[1]),
        .frameDone(o_fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 6 : 1;
    endfunction

    function automatic logic [3:0] pat(input int idx);
        int x, y;
        x = idx % W;
        y = idx / W;
        return 4'((x + 8 * y) % 16);
    endfunction

    function automatic vec_t mk(input bit rst, input bit sf, input bit vld,
                                input logic [3:0] pix, input bit rdy, input bit wv,
                                input bit chkpd, input logic [35:0] pd);
        vec_t v;
        v.rst = rst; v.sf = sf; v.vld = vld; v.pix = pix;
        v.rdy = rdy; v.wv = wv; v.chkpd = chkpd; v.pd = pd;
        return v;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic reset_stats();
        for (int k = 0; k < 2; k++) begin
            wv_cnt[k]  = 0;
            last_wv[k] = 0;
            min_sp[k]  = 1000000;
        end
    endtask

    // One clock: drive, predict from the raster/image model, then check outputs
    task automatic cycle(input bit rst, input bit sf, input bit v, input logic [3:0] p);
        bit acc, er;
        int pos, x, y;
        reset = rst; startFrame = sf; pixValid = v; pixIn = p;
        #1;
        obs_ready0 = o_rdy[0];
        for (int k = 0; k < 2; k++) begin
            er = !rst && ((cyc - last_emit[k]) >= longint'(gap_of(k)));
            chk("pixReady", k, 64'(o_rdy[k]), 64'(er));
            acc = v && er;
            if (rst) begin
                e_wv[k] = 0; e_fd[k] = 0; e_pd[k] = '0; e_x[k] = 0; e_y[k] = 0;
                m_idx[k] = 0; last_emit[k] = -1000;
            end else begin
                e_wv[k] = 0;
                e_fd[k] = 0;
                if (sf) begin
                    m_idx[k] = 0;
                    last_emit[k] = -1000;
                end
                if (acc) begin
                    pos = m_idx[k];
                    x = pos % W;
                    y = pos / W;
                    img[k][y][x] = p;
                    if (!sf && x >= 2 && y >= 2) begin
                        e_wv[k] = 1;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                e_pd[k][r][c] = img[k][y-2+r][x-2+c];
                        e_x[k] = x - 1;
                        e_y[k] = y - 1;
                        last_emit[k] = cyc;
                    end
                    e_fd[k] = (pos == W * H - 1);
                    m_idx[k] = (pos + 1) % (W * H);
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("windowValid", k, 64'(o_wv[k]), 64'(e_wv[k]));
            chk("frameDone",   k, 64'(o_fd[k]), 64'(e_fd[k]));
            chk("pixelData",   k, 64'(o_pd[k]), 64'(e_pd[k]));
            chk("winXVal",     k, 64'(o_x[k]),  64'(e_x[k]));
            chk("winYVal",     k, 64'(o_y[k]),  64'(e_y[k]));
            if (o_wv[k] === 1'b1) begin
                if (wv_cnt[k] > 0 && (cyc - last_wv[k]) < min_sp[k])
                    min_sp[k] = cyc - last_wv[k];
                wv_cnt[k]++;
                last_wv[k] = cyc;
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        logic [2:0][2:0][3:0] fp;
        int fd_cnt, fd_at;
        bit seen, first_seen;

        reset = 1'b1; startFrame = 1'b0; pixValid = 1'b0; pixIn = '0;
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; last_emit[k] = -1000; e_wv[k] = 0; e_fd[k] = 0;
            e_pd[k] = '0; e_x[k] = 0; e_y[k] = 0;
        end
        reset_stats();

        // Start of a full-rate frame on the MIN_GAP=6 instance
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                fp[r][c] = 4'(c + ((r == 1) ? 8 : 0));
        tbl.push_back(mk(1, 0, 1, 4'd0, 0, 0, 0, '0));
        for (int k = 0; k <= 2 * W + 2; k++)
            tbl.push_back(mk(0, k == 0, 1, pat(k), 1, k == 2 * W + 2, k == 2 * W + 2, fp));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 1, pat(2 * W + 3), 0, 0, 0, '0));
        tbl.push_back(mk(0, 0, 1, pat(2 * W + 3), 1, 1, 0, '0));

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].sf, tbl[i].vld, tbl[i].pix);
            chk("tbl_ready", 0, 64'(obs_ready0), 64'(tbl[i].rdy));
            chk("tbl_wv",    0, 64'(o_wv[0]),    64'(tbl[i].wv));
            if (tbl[i].chkpd) begin
                chk("tbl_first_pd", 0, 64'(o_pd[0]), 64'(tbl[i].pd));
                chk("tbl_first_x",  0, 64'(o_x[0]),  64'd1);
                chk("tbl_first_y",  0, 64'(o_y[0]),  64'd1);
            end
        end

        // Full frame, MIN_GAP=6: pulse count and spacing
        cycle(1, 0, 0, 4'd0);
        reset_stats();
        cycle(0, 1, 1, pat(0));
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle(0, 0, 1, pat(m_idx[0]));
            if (o_fd[0] === 1'b1) seen = 1;
        end
        chk("gap6_frame_done_seen", 0, 64'(seen), 64'd1);
        chk("gap6_window_count",    0, 64'(wv_cnt[0]), 64'd24);
        chk("gap6_min_spacing",     0, 64'(min_sp[0]), 64'd6);

        // Full frame, MIN_GAP=1: no stall, 24 windows in W*H+1 cycles
        cycle(1, 0, 0, 4'd0);
        reset_stats();
        fd_cnt = 0; fd_at = -1;
        for (int i = 0; i <= W * H; i++) begin
            if (i < W * H) cycle(0, i == 0, 1, 4'($urandom));
            else           cycle(0, 0, 0, 4'd0);
            if (o_fd[1] === 1'b1) begin
                fd_cnt++;
                fd_at = i;
            end
        end
        chk("gap1_window_count", 1, 64'(wv_cnt[1]), 64'd24);
        chk("gap1_fd_count",     1, 64'(fd_cnt),    64'd1);
        chk("gap1_fd_position",  1, 64'(fd_at),     64'(W * H - 1));

        // Random valid gaps with random image
        for (int i = 0; i < 600; i++)
            cycle(0, 0, ($urandom % 10) >= 3, 4'($urandom));

        // Restart mid row 3
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (m_idx[0] == 3 * W + 3) seen = 1;
            else cycle(0, 0, ($urandom % 10) >= 3, 4'($urandom));
        end
        chk("restart_point_reached", 0, 64'(seen), 64'd1);
        cycle(0, 1, 1, 4'($urandom));
        seen = 0; first_seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            cycle(0, 0, ($urandom % 10) >= 3, 4'($urandom));
            if (o_wv[0] === 1'b1 && !first_seen) begin
                first_seen = 1;
                chk("restart_first_x", 0, 64'(o_x[0]), 64'd1);
                chk("restart_first_y", 0, 64'(o_y[0]), 64'd1);
            end
            if (o_fd[0] === 1'b1) seen = 1;
        end
        chk("restart_window_seen", 0, 64'(first_seen), 64'd1);
        chk("restart_frame_done",  0, 64'(seen),       64'd1);

        // Reset while the throttle counter sits at 3
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle(0, 0, 1, 4'($urandom));
            if (o_wv[0] === 1'b1) seen = 1;
        end
        chk("gap_window_seen", 0, 64'(seen), 64'd1);
        cycle(0, 0, 1, 4'($urandom));
        cycle(0, 0, 1, 4'($urandom));
        cycle(1, 0, 1, 4'($urandom));
        chk("rst_wv_zero", 0, 64'(o_wv[0]), 64'd0);
        chk("rst_pd_zero", 0, 64'(o_pd[0]), 64'd0);
        chk("rst_x_zero",  0, 64'(o_x[0]),  64'd0);
        chk("rst_y_zero",  0, 64'(o_y[0]),  64'd0);
        reset_stats();
        for (int i = 0; i < 2 * W + 2; i++) begin
            cycle(0, 0, 1, 4'($urandom));
            if (i == 0) chk("rst_ready_after", 0, 64'(obs_ready0), 64'd1);
        end
        chk("rst_no_early_window", 0, 64'(wv_cnt[0]), 64'd0);
        cycle(0, 0, 1, 4'($urandom));
        chk("rst_window_at_2_2", 0, 64'(o_wv[0]), 64'd1);
        chk("rst_window_cx",     0, 64'(o_x[0]),  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
